exop64_wb_buf: RTL and testbench

- Writeback buffer sitting directly downstream of the 64-bit secondary execute unit.
- Takes the unit's combinational result triple (register id, value, status) and queues it in a 2-entry FIFO.
- Drains the FIFO into a shared GPR write port; the primary unit has priority on that port.
- Gives decode forwarding of pending results and a stall when the buffer is full.

---
 rtl/exop64_wb_buf.sv | 140 ++++++++++++++
 tb/tb_exop64_wb_buf.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exop64_wb_buf.sv
// Writeback buffer for the 64-bit secondary execute unit: 2-entry in-order FIFO draining into the shared GPR write port.
// Latency: an accepted result is visible on rfOut*/fwd* the cycle after acceptance; fault pulse is one cycle late.
// Backpressure: primary unit (rfPortBusy) holds the drain; wbOutStall asserts while full. Optional EXWB_COALESCE_EN merges same-id writes into the tail.
module exop64_wb_buf #(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        exInValid,
    input  logic [6:0]  exInId,
    input  logic [63:0] exInVal,
    input  logic [1:0]  exInOK,
    input  logic        rfPortBusy,
    output logic        rfOutWe,
    output logic [6:0]  rfOutId,
    output logic [63:0] rfOutVal,
    input  logic [6:0]  fwdQryId,
    output logic        fwdHit,
    output logic [63:0] fwdVal,
    output logic        wbOutStall,
    output logic        wbOutFault
);

    localparam logic [6:0] UREG_ZZR      = 7'h7F;
    localparam logic [1:0] UMEM_OK_OK    = 2'b00;
    localparam logic [1:0] UMEM_OK_HOLD  = 2'b01;
    localparam logic [1:0] UMEM_OK_FAULT = 2'b10;
    localparam logic [1:0] FULL_CNT      = 2'(DEPTH);

    logic [6:0]  id_q  [2];
    logic [6:0]  id_d  [2];
    logic [63:0] val_q [2];
    logic [63:0] val_d [2];
    logic        head_q, head_d;
    logic [1:0]  cnt_q,  cnt_d;
    logic        fault_q, fault_d;

    logic deq;
    logic enq;
    logic coalesce;
    logic alloc;
    logic lost;
    logic wr_idx;
    logic tail_idx;

    // Classify the incoming result and decide drain / allocate / merge for this cycle.
    always_comb begin
        deq      = (cnt_q != 2'd0) && !rfPortBusy;
        enq      = exInValid && (exInOK == UMEM_OK_OK) && (exInId != UREG_ZZR);
        fault_d  = exInValid && (exInOK == UMEM_OK_FAULT);
        // (head + count) mod 2 for the free slot, (head + count - 1) mod 2 for the newest entry.
        wr_idx   = head_q ^ cnt_q[0];
        tail_idx = head_q ^ cnt_q[1];
`ifdef EXWB_COALESCE_EN
        // A lone entry that is leaving this cycle cannot absorb a merge.
        coalesce = enq && (cnt_q != 2'd0) && (id_q[tail_idx] == exInId)
                   && !((cnt_q == 2'd1) && deq);
`else
        coalesce = 1'b0;
`endif
        alloc    = enq && !coalesce && ((cnt_q != FULL_CNT) || deq);
        lost     = enq && !coalesce && (cnt_q == FULL_CNT) && !deq;
    end

    // Next-state for entries, head and count; when full with deq, the slot written is the head being drained.
    always_comb begin
        id_d   = id_q;
        val_d  = val_q;
        head_d = head_q ^ deq;
        cnt_d  = cnt_q;
        if (alloc) begin
            id_d[wr_idx]  = exInId;
            val_d[wr_idx] = exInVal;
        end
        if (coalesce) begin
            val_d[tail_idx] = exInVal;
        end
        case ({alloc, deq})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers with synchronous active-low reset; reset discards any pending entries.
    always_ff @(posedge clock) begin
        if (!reset) begin
            id_q[0]  <= UREG_ZZR;
            id_q[1]  <= UREG_ZZR;
            val_q[0] <= 64'd0;
            val_q[1] <= 64'd0;
            head_q   <= 1'b0;
            cnt_q    <= 2'd0;
            fault_q  <= 1'b0;
        end else begin
            id_q    <= id_d;
            val_q   <= val_d;
            head_q  <= head_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // GPR port driven from the head entry; idle values when empty.
    always_comb begin
        rfOutWe    = deq;
        rfOutId    = UREG_ZZR;
        rfOutVal   = 64'd0;
        if (cnt_q != 2'd0) begin
            rfOutId  = id_q[head_q];
            rfOutVal = val_q[head_q];
        end
        wbOutStall = (cnt_q == FULL_CNT);
        wbOutFault = fault_q;
    end

    // Forwarding: head checked first, then the newer tail overrides; an entry draining now still counts.
    always_comb begin
        fwdHit = 1'b0;
        fwdVal = 64'd0;
        if (fwdQryId != UREG_ZZR) begin
            if ((cnt_q != 2'd0) && (id_q[head_q] == fwdQryId)) begin
                fwdHit = 1'b1;
                fwdVal = val_q[head_q];
            end
            if ((cnt_q == 2'd2) && (id_q[~head_q] == fwdQryId)) begin
                fwdHit = 1'b1;
                fwdVal = val_q[~head_q];
            end
        end
    end

    // Decode must honour wbOutStall, so a write request is never dropped for lack of space.
    a_no_lost_enq: assert property (@(posedge clock) disable iff (!reset) !lost);

    // HOLD and the undefined status encoding are intentionally ignored.
    logic unused_ok;
    assign unused_ok = (exInOK == UMEM_OK_HOLD);

endmodule

// File: tb/tb_exop64_wb_buf.sv
// Self-checking bench for exop64_wb_buf: queue-based reference model compared every cycle plus literal spot checks.
// Latency: outputs checked at the falling edge against the model state built from the previous rising edges.
// Backpressure: exercised through rfPortBusy; the bench never issues into a full, non-draining buffer.
module tb_exop64_wb_buf;

    localparam logic [6:0] ZZR   = 7'h7F;
    localparam logic [1:0] OK    = 2'b00;
    localparam logic [1:0] HOLD  = 2'b01;
    localparam logic [1:0] FAULT = 2'b10;

    localparam logic [63:0] VA = 64'hAAAA_0000_0000_0001;
    localparam logic [63:0] VB = 64'hBBBB_0000_0000_0002;
    localparam logic [63:0] VC = 64'hCCCC_0000_0000_0003;
    localparam logic [63:0] VD = 64'hDDDD_0000_0000_0004;
    localparam logic [63:0] VP = 64'h5555_0000_0000_0008;
    localparam logic [63:0] VQ = 64'h6666_0000_0000_0009;
    localparam logic [63:0] VX = 64'h1111_0000_0000_7777;
    localparam logic [63:0] VY = 64'h2222_0000_0000_7777;

    logic        clock;
    logic        reset;
    logic        exInValid;
    logic [6:0]  exInId;
    logic [63:0] exInVal;
    logic [1:0]  exInOK;
    logic        rfPortBusy;
    logic        rfOutWe;
    logic [6:0]  rfOutId;
    logic [63:0] rfOutVal;
    logic [6:0]  fwdQryId;
    logic        fwdHit;
    logic [63:0] fwdVal;
    logic        wbOutStall;
    logic        wbOutFault;

    exop64_wb_buf #(.DEPTH(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .exInValid  (exInValid),
        .exInId     (exInId),
        .exInVal    (exInVal),
        .exInOK     (exInOK),
        .rfPortBusy (rfPortBusy),
        .rfOutWe    (rfOutWe),
        .rfOutId    (rfOutId),
        .rfOutVal   (rfOutVal),
        .fwdQryId   (fwdQryId),
        .fwdHit     (fwdHit),
        .fwdVal     (fwdVal),
        .wbOutStall (wbOutStall),
        .wbOutFault (wbOutFault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of pending writes plus the fault pulse.
    typedef struct packed {
        logic [6:0]  id;
        logic [63:0] val;
    } ent_t;

    ent_t m_q[$];
    logic m_fault = 1'b0;

    always @(posedge clock) begin
        int  n;
        bit  drain;
        bit  wreq;
        bit  merge;
        if (!reset) begin
            m_q.delete();
            m_fault = 1'b0;
        end else begin
            n     = m_q.size();
            drain = (n != 0) && !rfPortBusy;
            wreq  = exInValid && (exInOK == OK) && (exInId != ZZR);
            merge = 1'b0;
`ifdef EXWB_COALESCE_EN
            merge = wreq && (n != 0) && (m_q[n-1].id == exInId) && !(n == 1 && drain);
`endif
            m_fault = exInValid && (exInOK == FAULT);
            if (drain) void'(m_q.pop_front());
            if (merge) begin
                m_q[m_q.size()-1].val = exInVal;
            end else if (wreq) begin
                if (n < 2 || drain) m_q.push_back('{id: exInId, val: exInVal});
                else chk("model_lost_enq", 64'd1, 64'd0);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        logic        e_we, e_hit;
        logic [6:0]  e_id;
        logic [63:0] e_val, e_fv;
        if (chk_en) begin
            e_we  = (m_q.size() != 0) && !rfPortBusy;
            e_id  = (m_q.size() != 0) ? m_q[0].id  : ZZR;
            e_val = (m_q.size() != 0) ? m_q[0].val : 64'd0;
            e_hit = 1'b0;
            e_fv  = 64'd0;
            if (fwdQryId != ZZR) begin
                foreach (m_q[i]) begin
                    if (m_q[i].id == fwdQryId) begin
                        e_hit = 1'b1;
                        e_fv  = m_q[i].val;
                    end
                end
            end
            chk("cyc_rfOutWe",    64'(rfOutWe),    64'(e_we));
            chk("cyc_rfOutId",    64'(rfOutId),    64'(e_id));
            chk("cyc_rfOutVal",   rfOutVal,        e_val);
            chk("cyc_fwdHit",     64'(fwdHit),     64'(e_hit));
            chk("cyc_fwdVal",     fwdVal,          e_fv);
            chk("cyc_wbOutStall", 64'(wbOutStall), 64'(m_q.size() == 2));
            chk("cyc_wbOutFault", 64'(wbOutFault), 64'(m_fault));
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic put(input logic [6:0] id, input logic [63:0] v, input logic [1:0] ok);
        exInValid = 1'b1;
        exInId    = id;
        exInVal   = v;
        exInOK    = ok;
    endtask

    task automatic idle_in();
        exInValid = 1'b0;
        exInId    = ZZR;
        exInVal   = 64'd0;
        exInOK    = OK;
    endtask

    initial begin
        // Reset held for two edges while EX presents a valid OK result.
        reset      = 1'b0;
        rfPortBusy = 1'b0;
        fwdQryId   = ZZR;
        put(7'd5, VD, OK);
        step();
        step();
        reset = 1'b1;
        idle_in();
        fwdQryId = 7'd5;
        chk_en = 1'b1;
        settle();
        chk("rst_we",    64'(rfOutWe),    64'd0);
        chk("rst_id",    64'(rfOutId),    64'(ZZR));
        chk("rst_stall", 64'(wbOutStall), 64'd0);
        chk("rst_fault", 64'(wbOutFault), 64'd0);
        chk("rst_fwd",   64'(fwdHit),     64'd0);

        // Single result with the port free.
        put(7'd3, 64'h1234, OK);
        step();
        idle_in();
        fwdQryId = 7'd3;
        settle();
        chk("single_we",   64'(rfOutWe), 64'd1);
        chk("single_id",   64'(rfOutId), 64'd3);
        chk("single_val",  rfOutVal,     64'h1234);
        chk("single_hit",  64'(fwdHit),  64'd1);
        chk("single_fwd",  fwdVal,       64'h1234);
        step();
        settle();
        chk("single_empty_we",  64'(rfOutWe), 64'd0);
        chk("single_empty_hit", 64'(fwdHit),  64'd0);
        fwdQryId = ZZR;

        // Port busy: fill, then drain in order.
        rfPortBusy = 1'b1;
        put(7'd1, VA, OK);
        step();
        put(7'd2, VB, OK);
        step();
        idle_in();
        settle();
        chk("busy_stall", 64'(wbOutStall), 64'd1);
        chk("busy_we",    64'(rfOutWe),    64'd0);
        chk("busy_id",    64'(rfOutId),    64'd1);
        rfPortBusy = 1'b0;
        settle();
        chk("drain1_we",  64'(rfOutWe), 64'd1);
        chk("drain1_val", rfOutVal,     VA);
        step();
        settle();
        chk("drain2_id",    64'(rfOutId),    64'd2);
        chk("drain2_val",   rfOutVal,        VB);
        chk("drain2_stall", 64'(wbOutStall), 64'd0);
        step();
        settle();
        chk("drain_done", 64'(rfOutWe), 64'd0);

        // Full buffer with simultaneous enqueue and dequeue.
        rfPortBusy = 1'b1;
        put(7'd1, VA, OK);
        step();
        put(7'd2, VB, OK);
        step();
        rfPortBusy = 1'b0;
        put(7'd4, VC, OK);
        settle();
        chk("full_stall", 64'(wbOutStall), 64'd1);
        chk("full_id1",   64'(rfOutId),    64'd1);
        step();
        idle_in();
        settle();
        chk("full_stall2", 64'(wbOutStall), 64'd1);
        chk("full_id2",    64'(rfOutId),    64'd2);
        step();
        settle();
        chk("full_stall3", 64'(wbOutStall), 64'd0);
        chk("full_id4",    64'(rfOutId),    64'd4);
        chk("full_val4",   rfOutVal,        VC);
        step();

        // Status handling: HOLD, FAULT, ZZR drop, undefined encoding.
        put(7'd6, VD, HOLD);
        step();
        idle_in();
        settle();
        chk("hold_we", 64'(rfOutWe), 64'd0);
        put(7'd6, VD, FAULT);
        step();
        idle_in();
        settle();
        chk("fault_pulse", 64'(wbOutFault), 64'd1);
        chk("fault_we",    64'(rfOutWe),    64'd0);
        step();
        settle();
        chk("fault_clear", 64'(wbOutFault), 64'd0);
        put(ZZR, VD, OK);
        step();
        idle_in();
        settle();
        chk("zzr_we", 64'(rfOutWe), 64'd0);
        put(7'd6, VD, 2'b11);
        step();
        idle_in();
        settle();
        chk("undef_we", 64'(rfOutWe), 64'd0);

        // Forwarding with two distinct ids.
        rfPortBusy = 1'b1;
        put(7'd8, VP, OK);
        step();
        put(7'd9, VQ, OK);
        step();
        idle_in();
        fwdQryId = 7'd8;
        settle();
        chk("fwd_head", fwdVal, VP);
        fwdQryId = 7'd9;
        settle();
        chk("fwd_tail", fwdVal, VQ);
        fwdQryId = ZZR;
        settle();
        chk("fwd_zzr", 64'(fwdHit), 64'd0);
        rfPortBusy = 1'b0;
        step();
        step();

        // Same id twice while busy: newest value wins.
        rfPortBusy = 1'b1;
        put(7'd7, VX, OK);
        step();
        put(7'd7, VY, OK);
        step();
        idle_in();
        fwdQryId = 7'd7;
        settle();
        chk("fwd7_hit", 64'(fwdHit), 64'd1);
        chk("fwd7_val", fwdVal,      VY);
`ifdef EXWB_COALESCE_EN
        chk("co_stall", 64'(wbOutStall), 64'd0);
        chk("co_head",  rfOutVal,        VY);
`else
        chk("nc_stall", 64'(wbOutStall), 64'd1);
        chk("nc_head",  rfOutVal,        VX);
`endif
        rfPortBusy = 1'b0;
        step();
        settle();
`ifdef EXWB_COALESCE_EN
        chk("co_after", 64'(rfOutWe), 64'd0);
`else
        chk("nc_second", rfOutVal, VY);
`endif
        step();
        fwdQryId = ZZR;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
